// File: rtl/ser_deserializer.sv
// Serial-to-parallel packer: collects MSB-first bits into WIDTH-bit words and
// flushes a short right-aligned word when the qualified serial stream ends.
module ser_deserializer #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clk_en_i,
   input  logic             ser_i,
   input  logic             ser_valid_i,
   output logic [WIDTH-1:0] par_o,
   output logic [CW-1:0]    par_len_o,
   output logic             par_valid_o,
   output logic             frame_done_o,
   output logic [CW-1:0]    bit_count_o
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_e;

   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
   localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shift_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] par_q;
   logic [CW-1:0]    par_len_q;
   logic             par_valid_q;
   logic             frame_done_q;

   // Shift register contents once the current bit is appended at bit 0.
   always_comb begin
      shift_d = {shreg_q[WIDTH-2:0], ser_i};
   end

   // Frame FSM, shift register and registered word/pulse outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         shreg_q      <= W_ZERO;
         count_q      <= CNT_ZERO;
         par_q        <= W_ZERO;
         par_len_q    <= CNT_ZERO;
         par_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // Pulses last one clock regardless of the bit-rate enable.
         par_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (clk_en_i) begin
            case (state_q)
               S_IDLE: begin
                  if (ser_valid_i) begin
                     shreg_q <= {{(WIDTH-1){1'b0}}, ser_i};
                     count_q <= CNT_ONE;
                     state_q <= S_COLLECT;
                  end
               end
               S_COLLECT: begin
                  if (ser_valid_i) begin
                     if (count_q == CNT_LAST) begin
                        par_q       <= shift_d;
                        par_len_q   <= CNT_FULL;
                        par_valid_q <= 1'b1;
                        count_q     <= CNT_ZERO;
                        shreg_q     <= W_ZERO;
                     end else begin
                        shreg_q <= shift_d;
                        count_q <= count_q + CNT_ONE;
                     end
                  end else begin
                     // Any drop of the qualifier ends the frame; flush leftovers.
                     if (count_q != CNT_ZERO) begin
                        par_q       <= shreg_q;
                        par_len_q   <= count_q;
                        par_valid_q <= 1'b1;
                     end
                     frame_done_q <= 1'b1;
                     count_q      <= CNT_ZERO;
                     shreg_q      <= W_ZERO;
                     state_q      <= S_IDLE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  count_q <= CNT_ZERO;
                  shreg_q <= W_ZERO;
               end
            endcase
         end
      end
   end

   assign par_o        = par_q;
   assign par_len_o    = par_len_q;
   assign par_valid_o  = par_valid_q;
   assign frame_done_o = frame_done_q;
   assign bit_count_o  = count_q;

endmodule

// File: tb/tb_ser_deserializer.sv
// Randomized scoreboard bench for ser_deserializer: a frame-level model queues
// expected word/frame-end events, a negedge monitor pops and compares them.
module tb_ser_deserializer;

   localparam int WIDTH = 8;
   localparam int CW    = 4;

   logic             clk         = 1'b0;
   logic             rst_ni      = 1'b0;
   logic             clk_en_i    = 1'b0;
   logic             ser_i       = 1'b0;
   logic             ser_valid_i = 1'b0;
   logic [WIDTH-1:0] par_o;
   logic [CW-1:0]    par_len_o;
   logic             par_valid_o;
   logic             frame_done_o;
   logic [CW-1:0]    bit_count_o;

   ser_deserializer #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .clk_en_i     (clk_en_i),
      .ser_i        (ser_i),
      .ser_valid_i  (ser_valid_i),
      .par_o        (par_o),
      .par_len_o    (par_len_o),
      .par_valid_o  (par_valid_o),
      .frame_done_o (frame_done_o),
      .bit_count_o  (bit_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             v;
      logic             d;
      logic [WIDTH-1:0] par;
      logic [CW-1:0]    len;
   } ev_t;

   ev_t exp_q[$];
   bit  frame_q[$];
   bit  in_frame = 1'b0;
   bit  tb_done  = 1'b0;
   int  cmp_n    = 0;
   int  bad_n    = 0;
   logic [WIDTH-1:0] hold_par = '0;
   logic [CW-1:0]    hold_len = '0;

   function automatic void chk(input string name, input int act, input int exp);
      cmp_n++;
      if (act != exp) begin
         bad_n++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Word value of the bits gathered so far, first bit most significant.
   function automatic ev_t pack_frame();
      ev_t e;
      int  val;
      val = 0;
      foreach (frame_q[i]) val = val * 2 + int'(frame_q[i]);
      e.v   = 1'b1;
      e.d   = 1'b0;
      e.par = val[WIDTH-1:0];
      e.len = CW'(frame_q.size());
      frame_q.delete();
      return e;
   endfunction

   function automatic void model_step(input bit en, input bit v, input bit b);
      ev_t e;
      if (en) begin
         if (v) begin
            frame_q.push_back(b);
            in_frame = 1'b1;
            if (frame_q.size() == WIDTH) exp_q.push_back(pack_frame());
         end else if (in_frame) begin
            if (frame_q.size() > 0) e = pack_frame();
            else e = '0;
            e.d = 1'b1;
            exp_q.push_back(e);
            in_frame = 1'b0;
         end
      end
   endfunction

   task automatic step(input bit en, input bit v, input bit b);
      clk_en_i    = en;
      ser_valid_i = v;
      ser_i       = b;
      @(posedge clk);
      model_step(en, v, b);
      #1;
   endtask

   // Monitor: all comparisons happen here, away from the rising edge.
   always @(negedge clk) begin
      ev_t e;
      if (!rst_ni) begin
         chk("rst_par", int'(par_o), 0);
         chk("rst_len", int'(par_len_o), 0);
         chk("rst_valid", int'(par_valid_o), 0);
         chk("rst_done", int'(frame_done_o), 0);
         chk("rst_bitcount", int'(bit_count_o), 0);
         hold_par = '0;
         hold_len = '0;
      end else begin
         if (par_valid_o || frame_done_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("valid_flag", int'(par_valid_o), int'(e.v));
               chk("done_flag", int'(frame_done_o), int'(e.d));
               if (e.v) begin
                  hold_par = e.par;
                  hold_len = e.len;
               end
            end
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("missing_pulse", 0, 1);
         end
         chk("par_o", int'(par_o), int'(hold_par));
         chk("par_len", int'(par_len_o), int'(hold_len));
         chk("bit_count", int'(bit_count_o), frame_q.size());
      end
      if (tb_done) begin
         chk("queue_drained", exp_q.size(), 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: directed scenarios followed by a randomized soak.
   initial begin
      logic [7:0] pat;
      pat = 8'hB2;
      repeat (4) begin
         clk_en_i    = 1'b1;
         ser_i       = 1'($urandom);
         ser_valid_i = 1'($urandom);
         @(posedge clk);
         #1;
      end
      ser_valid_i = 1'b0;
      rst_ni      = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, pat[i]);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      for (int i = 7; i >= 0; i--) begin
         if (i == 4) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1);
         end
         step(1'b1, 1'b1, pat[i]);
      end
      step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom));
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'($urandom));
      ser_valid_i = 1'b0;
      #1;
      rst_ni = 1'b0;
      exp_q.delete();
      frame_q.delete();
      in_frame = 1'b0;
      @(negedge clk);
      #2;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0), 1'($urandom));

      repeat (3) step(1'b1, 1'b0, 1'b0);
      tb_done = 1'b1;
   end

endmodule
